// File: rtl/demux_16w_1to2_buf.sv
// demux_16w_1to2_buf: registered 1-to-2 demultiplexer for datapath words.
// Each accepted word is steered by Sel into one of two independent FIFO
// queues (A when Sel=1, B when Sel=0). Each queue drains through its own
// valid/ready port, so one stalled consumer never blocks the other.

module demux_16w_1to2_buf_q #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     ready,
   input  logic [WIDTH-1:0]         d,
   output logic                     valid,
   output logic                     full,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop;

   assign valid = (count != '0);
   assign full  = (count == CW'(DEPTH));
   // A pop with an empty queue is ignored; the head is forced to zero when empty.
   assign pop   = valid && ready;
   assign head  = valid ? mem[rd_ptr] : '0;

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= d;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module demux_16w_1to2_buf #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic                     Sel,
   input  logic [WIDTH-1:0]         D,
   output logic                     A_Valid,
   input  logic                     A_Ready,
   output logic [WIDTH-1:0]         A,
   output logic [$clog2(DEPTH):0]   A_Count,
   output logic                     B_Valid,
   input  logic                     B_Ready,
   output logic [WIDTH-1:0]         B,
   output logic [$clog2(DEPTH):0]   B_Count
);
   logic a_full;
   logic b_full;
   logic accept;
   logic push_a;
   logic push_b;

   // Readiness looks only at the selected queue; a full queue never passes
   // a word through even if it pops in the same cycle.
   assign In_Ready = !Reset && (Sel ? !a_full : !b_full);
   assign accept   = In_Valid && In_Ready;
   assign push_a   = accept && Sel;
   assign push_b   = accept && !Sel;

   demux_16w_1to2_buf_q #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_qa (
      .clk   (Clk),
      .rst   (Reset),
      .push  (push_a),
      .ready (A_Ready),
      .d     (D),
      .valid (A_Valid),
      .full  (a_full),
      .head  (A),
      .count (A_Count)
   );

   demux_16w_1to2_buf_q #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_qb (
      .clk   (Clk),
      .rst   (Reset),
      .push  (push_b),
      .ready (B_Ready),
      .d     (D),
      .valid (B_Valid),
      .full  (b_full),
      .head  (B),
      .count (B_Count)
   );
endmodule

// File: tb/tb_demux_16w_1to2_buf.sv
// Testbench for demux_16w_1to2_buf: directed scenarios plus a random phase,
// with a scoreboard holding one reference queue per output.

module tb_demux_16w_1to2_buf;
   localparam int DEPTH = 2;
   localparam int WIDTH = 16;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             In_Valid;
   logic             In_Ready;
   logic             Sel;
   logic [WIDTH-1:0] D;
   logic             A_Valid;
   logic             A_Ready;
   logic [WIDTH-1:0] A;
   logic [1:0]       A_Count;
   logic             B_Valid;
   logic             B_Ready;
   logic [WIDTH-1:0] B;
   logic [1:0]       B_Count;

   int n_chk = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   logic [WIDTH-1:0] qa [$];
   logic [WIDTH-1:0] qb [$];

   demux_16w_1to2_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .In_Valid (In_Valid),
      .In_Ready (In_Ready),
      .Sel      (Sel),
      .D        (D),
      .A_Valid  (A_Valid),
      .A_Ready  (A_Ready),
      .A        (A),
      .A_Count  (A_Count),
      .B_Valid  (B_Valid),
      .B_Ready  (B_Ready),
      .B        (B),
      .B_Count  (B_Count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard: inputs are stable at the falling edge, so the handshakes seen
   // here are the ones the next rising edge will act on.
   always @(negedge Clk) begin
      if (mon_en) begin
         chk("sb_a_count", 32'(A_Count), 32'(qa.size()));
         chk("sb_b_count", 32'(B_Count), 32'(qb.size()));
         chk("sb_a_valid", 32'(A_Valid), 32'(qa.size() != 0));
         chk("sb_b_valid", 32'(B_Valid), 32'(qb.size() != 0));
         chk("sb_in_ready", 32'(In_Ready),
             32'(!Reset && (Sel ? (qa.size() != DEPTH) : (qb.size() != DEPTH))));
         if (qa.size() == 0) chk("sb_a_empty_zero", 32'(A), 32'h0);
         if (qb.size() == 0) chk("sb_b_empty_zero", 32'(B), 32'h0);
         if (Reset) begin
            qa.delete();
            qb.delete();
         end else begin
            if (A_Valid && A_Ready && qa.size() != 0) chk("sb_a_data", 32'(A), 32'(qa.pop_front()));
            if (B_Valid && B_Ready && qb.size() != 0) chk("sb_b_data", 32'(B), 32'(qb.pop_front()));
            if (In_Valid && In_Ready) begin
               if (Sel) qa.push_back(D);
               else     qb.push_back(D);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset with a word offered
      Reset = 1'b1; In_Valid = 1'b1; Sel = 1'b1; D = 16'hDEAD;
      A_Ready = 1'b0; B_Ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(In_Ready), 32'h0);
      tick();
      mon_en = 1'b1;
      chk("rst_a_valid", 32'(A_Valid), 32'h0);
      chk("rst_b_valid", 32'(B_Valid), 32'h0);
      chk("rst_a", 32'(A), 32'h0);
      chk("rst_b", 32'(B), 32'h0);
      chk("rst_a_count", 32'(A_Count), 32'h0);
      chk("rst_b_count", 32'(B_Count), 32'h0);
      tick();
      Reset = 1'b0; In_Valid = 1'b0;

      // 2: one word to each side, consumers always ready
      A_Ready = 1'b1; B_Ready = 1'b1;
      In_Valid = 1'b1; Sel = 1'b1; D = 16'hAAAA;
      tick();
      chk("basic_a", 32'(A), 32'hAAAA);
      chk("basic_a_valid", 32'(A_Valid), 32'h1);
      Sel = 1'b0; D = 16'hBBBB;
      tick();
      In_Valid = 1'b0;
      chk("basic_b", 32'(B), 32'hBBBB);
      chk("basic_b_valid", 32'(B_Valid), 32'h1);
      chk("basic_a_drained", 32'(A_Count), 32'h0);
      tick();
      chk("basic_b_drained", 32'(B_Count), 32'h0);

      // 3: fill A, B still accepts, then drain A in order
      A_Ready = 1'b0; B_Ready = 1'b0;
      In_Valid = 1'b1; Sel = 1'b1; D = 16'h0001;
      tick();
      D = 16'h0002;
      tick();
      D = 16'h0005;
      #1;
      chk("full_a_count", 32'(A_Count), 32'h2);
      chk("full_a_in_ready", 32'(In_Ready), 32'h0);
      Sel = 1'b0; D = 16'h0003;
      #1;
      chk("full_b_in_ready", 32'(In_Ready), 32'h1);
      tick();
      In_Valid = 1'b0;
      A_Ready = 1'b1; B_Ready = 1'b1;
      chk("drain_a_first", 32'(A), 32'h0001);
      tick();
      chk("drain_a_second", 32'(A), 32'h0002);
      tick();
      chk("drain_a_empty", 32'(A_Valid), 32'h0);

      // 4: simultaneous push and pop at count 1 across pointer wrap
      In_Valid = 1'b1; Sel = 1'b1; D = 16'h4FFF;
      tick();
      for (int i = 0; i < 8; i++) begin
         D = 16'h4000 + 16'(i);
         tick();
         chk("pp_count", 32'(A_Count), 32'h1);
         chk("pp_head", 32'(A), 32'h4000 + 32'(i));
      end
      In_Valid = 1'b0;
      tick();

      // 5: reset mid-stream flushes both queues
      A_Ready = 1'b0; B_Ready = 1'b0;
      In_Valid = 1'b1; Sel = 1'b1; D = 16'h0A01;
      tick();
      D = 16'h0A02;
      tick();
      Sel = 1'b0; D = 16'h0B01;
      tick();
      Reset = 1'b1; D = 16'hDEAD;
      tick();
      Reset = 1'b0;
      chk("flush_a_valid", 32'(A_Valid), 32'h0);
      chk("flush_b_valid", 32'(B_Valid), 32'h0);
      chk("flush_a_count", 32'(A_Count), 32'h0);
      chk("flush_b_count", 32'(B_Count), 32'h0);
      D = 16'h1234;
      tick();
      In_Valid = 1'b0;
      chk("flush_b_word", 32'(B), 32'h1234);
      chk("flush_b_alone", 32'(B_Count), 32'h1);
      B_Ready = 1'b1;
      tick();
      chk("flush_b_gone", 32'(B_Count), 32'h0);

      // 6: random traffic against the scoreboard
      for (int i = 0; i < 200; i++) begin
         In_Valid = 1'($urandom_range(0, 1));
         Sel      = 1'($urandom_range(0, 1));
         D        = 16'($urandom);
         A_Ready  = 1'($urandom_range(0, 1));
         B_Ready  = 1'($urandom_range(0, 1));
         tick();
      end
      In_Valid = 1'b0; A_Ready = 1'b1; B_Ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("final_qa_empty", 32'(qa.size()), 32'h0);
      chk("final_qb_empty", 32'(qb.size()), 32'h0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/demux_16w_1to2_buf.md
Name: demux_16w_1to2_buf

Overview:
- Registered 1-to-2 demultiplexer for 16-bit datapath words.
- Accepts one word per cycle on a valid/ready input and steers it by Sel into one of two independent output queues, A or B, each with valid/ready.
- Used where one datapath result must be delivered to one of two consumers, such as register-file writeback versus memory-store path.
- Each queue can stall independently without losing data.

Parameters:
DEPTH, 2, entries per output queue; power of two, minimum 2.
WIDTH, 16, data word width.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
In_Valid  input  1  D and Sel are valid this cycle.
In_Ready  output  1  block accepts the word this cycle.
Sel  input  1  destination select: 1 = queue A, 0 = queue B.
D  input  WIDTH  input data word.
A_Valid  output  1  queue A head is valid.
A_Ready  input  1  consumer A takes the head this cycle.
A  output  WIDTH  queue A head data.
A_Count  output  log2(DEPTH)+1  entries held in queue A.
B_Valid  output  1  queue B head is valid.
B_Ready  input  1  consumer B takes the head this cycle.
B  output  WIDTH  queue B head data.
B_Count  output  log2(DEPTH)+1  entries held in queue B.

Behaviour:
- One clock, Clk. Reset is synchronous and active-high; all state updates on the rising edge of Clk.
- Reset values: A_Valid=0, B_Valid=0, A=B=16'h0000, A_Count=B_Count=0. Storage and pointers are cleared. In_Ready=0 while Reset=1.
- In_Ready is combinational: !Reset && (Sel ? A_Count!=DEPTH : B_Count!=DEPTH).
- In_Ready depends only on the selected queue. A full queue A does not block words to B, and vice versa.
- Accept occurs when In_Valid && In_Ready. The word is written to the selected queue's tail.
- Latency: an accepted word is visible at the head no earlier than the next cycle. There is no same-cycle bypass.
- Pop occurs when X_Valid && X_Ready. The head advances and the next entry appears on the following cycle.
- X_Ready while X_Valid=0 is ignored.
- X_Valid = (X_Count != 0). X shows the head entry, or 16'h0000 when empty.
- Push and pop on the same queue in one cycle, queue neither empty nor full: count is unchanged and FIFO order is preserved.
- Full queue: In_Ready=0 for that Sel, even if that queue is popping in the same cycle. There is no full-pass-through.
- Empty queue with a push: count becomes 1 next cycle, and X_Valid rises next cycle.
- Pointers wrap modulo DEPTH. Counts never exceed DEPTH and never go below 0.
- Ordering: words with the same Sel leave in acceptance order. There is no ordering guarantee between A and B.
- Sel and D are sampled only on accept. Values at other times have no effect.
- Producer must hold D/Sel stable while In_Valid && !In_Ready. The block does not check this.
- Consumers must hold X_Ready meaningfully only when X_Valid=1.
- Reset mid-operation flushes both queues. Contents are discarded, and both Valids are 0 on the cycle after Reset is sampled high. Any word offered during the Reset cycle is not accepted.
- No X or Z states on any output after the first reset.

Test Plan:
1. Reset with In_Valid=1 -> In_Ready=0; next cycle A_Valid=B_Valid=0, A=B=16'h0000, both counts 0.
2. Accept D=16'hAAAA with Sel=1, then D=16'hBBBB with Sel=0; both Readys held 1.
   - A=16'hAAAA with A_Valid=1 one cycle after its accept.
   - B=16'hBBBB with B_Valid=1 one cycle after its accept.
   - Each pops after one cycle; counts return to 0.
3. Hold A_Ready=0 and push 16'h0001 then 16'h0002 to A with DEPTH=2.
   - A_Count=2 and In_Ready=0 for Sel=1.
   - Sel=0 push of 16'h0003 is still accepted.
   - Raise A_Ready: A outputs 16'h0001 then 16'h0002 in order.
4. Queue A at count 1 with push and pop in the same cycle -> A_Count stays 1 and the head updates to the new word next cycle.
   - Repeat for 8 cycles to cross pointer wrap; data order is intact.
5. Fill A with 2 words and B with 1 word, assert Reset for one cycle mid-stream -> all Valids 0 and counts 0 next cycle; the subsequent push of 16'h1234 to B emerges alone.
6. Random: 200 cycles of random In_Valid, Sel, D and random A_Ready/B_Ready against a scoreboard with two reference queues -> every popped word matches the model; no loss, duplication or reordering within a queue.
